// File: rtl/spi_reg_decoder.sv
// Command decoder between the SPI byte interface and the PWM register file.
// Optional build macro: SPI_DECODER_BURST_EN (auto-increment burst access).
module spi_reg_decoder #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 6'h0D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_load,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_WR,
    S_RD,
    S_TX,
`ifdef SPI_DECODER_BURST_EN
    S_SKIP,
    S_RD_WAIT
`else
    S_SKIP
`endif
  } state_t;

  state_t              state_q;
  logic [1:0]          rst_sync_q;
  logic                rst_sync_n;
  logic                cs_n_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_write_q;
  logic [DATA_W-1:0]   tx_byte_q;
  logic                read_q;
  logic                write_q;
  logic                tx_load_q;
  logic                err_q;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                cmd_illegal;

  assign cmd_addr    = rx_byte[ADDR_W-1:0];
  assign cmd_illegal = (cmd_addr > MAX_ADDR);

`ifdef SPI_DECODER_BURST_EN
  logic [ADDR_W-1:0] addr_inc;
  logic              addr_inc_illegal;
  // Natural ADDR_W-bit wrap gives the 3F -> 00 roll-over.
  assign addr_inc         = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign addr_inc_illegal = (addr_inc > MAX_ADDR);
`endif

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q      <= S_IDLE;
      cs_n_q       <= 1'b1;
      addr_q       <= '0;
      data_write_q <= '0;
      tx_byte_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      tx_load_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cs_n_q    <= cs_n;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      tx_load_q <= 1'b0;

      // Frame end has priority: it discards pending accesses and any strobe due now.
      if (cs_n) begin
        state_q <= S_IDLE;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cs_n_q) state_q <= S_CMD;
          end

          S_CMD: begin
            if (rx_valid) begin
              addr_q <= cmd_addr;
              if (cmd_illegal) begin
                err_q   <= 1'b1;
                state_q <= S_SKIP;
              end else if (rx_byte[DATA_W-1]) begin
                state_q <= S_WDATA;
              end else begin
                read_q  <= 1'b1;
                state_q <= S_RD;
              end
            end
          end

          S_WDATA: begin
            if (rx_valid) begin
              data_write_q <= rx_byte;
              write_q      <= 1'b1;
              state_q      <= S_WR;
            end
          end

          S_WR: begin
            if (rx_valid) err_q <= 1'b1;
`ifdef SPI_DECODER_BURST_EN
            if (addr_inc_illegal) begin
              err_q   <= 1'b1;
              state_q <= S_SKIP;
            end else begin
              addr_q  <= addr_inc;
              state_q <= S_WDATA;
            end
`else
            state_q <= S_CMD;
`endif
          end

          S_RD: begin
            if (rx_valid) err_q <= 1'b1;
            tx_byte_q <= data_read;
            tx_load_q <= 1'b1;
            state_q   <= S_TX;
          end

          S_TX: begin
            if (rx_valid) err_q <= 1'b1;
`ifdef SPI_DECODER_BURST_EN
            if (addr_inc_illegal) begin
              err_q   <= 1'b1;
              state_q <= S_SKIP;
            end else begin
              state_q <= S_RD_WAIT;
            end
`else
            state_q <= S_CMD;
`endif
          end

`ifdef SPI_DECODER_BURST_EN
          // The dummy byte of the previous read paces the next one.
          S_RD_WAIT: begin
            if (rx_valid) begin
              addr_q  <= addr_inc;
              read_q  <= 1'b1;
              state_q <= S_RD;
            end
          end
`endif

          S_SKIP: begin
            if (rx_valid) state_q <= S_CMD;
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_load    = tx_load_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = data_write_q;
  assign err        = err_q;

endmodule
